// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory stage: control bit positions, write-back
// select encodings and FSM states.
package mem_wb_stage_pkg;

    localparam int CTL_BUBBLE   = 0;
    localparam int CTL_MREAD    = 1;
    localparam int CTL_MWRITE   = 2;
    localparam int CTL_REGW     = 3;
    localparam int CTL_WBSEL_LO = 4;
    localparam int CTL_WBSEL_HI = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Request/acknowledge data-memory bus between the memory stage and memory.
interface mem_wb_stage_if #(
    parameter int DATA_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_wb_stage_reg.sv
// MEM/WB pipeline register. A bubble clears only the write enable; data and
// destination keep their previous values.
module mem_wb_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_bubble,
    input  logic [DATA_W-1:0] i_data,
    input  logic [4:0]        i_regdst,
    input  logic              i_regwrite,
    output logic [DATA_W-1:0] o_data,
    output logic [4:0]        o_regdst,
    output logic              o_regwrite
);
    logic [DATA_W-1:0] r_data;
    logic [4:0]        r_regdst;
    logic              r_regwrite;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data     <= '0;
            r_regdst   <= '0;
            r_regwrite <= 1'b0;
        end else if (i_bubble) begin
            r_regwrite <= 1'b0;
        end else if (i_load) begin
            r_data     <= i_data;
            r_regdst   <= i_regdst;
            r_regwrite <= i_regwrite;
        end
    end

    assign o_data     = r_data;
    assign o_regdst   = r_regdst;
    assign o_regwrite = r_regwrite;
endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage with MEM/WB register; stalls upstream while a bus access
// is outstanding. Optional access timeout enabled by MEM_TIMEOUT_EN.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        control_in,
    input  logic [DATA_W-1:0] pc_4_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] sw_in,
    input  logic [4:0]        regdst_in,
    mem_wb_stage_if.master    dmem,
    output logic              stall,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_regdst,
    output logic              wb_regwrite,
    output logic              mem_err
);
    state_e            r_state, w_next;
    logic              r_req, r_we;
    logic              w_access, w_stall, w_load, w_bubble, w_regwrite, w_expire;
    logic [DATA_W-1:0] w_wb_val;
    wb_sel_e           w_wbsel;
    logic              w_unused_ctl;

    assign w_unused_ctl = control_in[6];
    assign w_access = !control_in[CTL_BUBBLE] &
                      (control_in[CTL_MREAD] | control_in[CTL_MWRITE]);
    assign w_wbsel  = wb_sel_e'(control_in[CTL_WBSEL_HI:CTL_WBSEL_LO]);

    always_comb begin
        case (w_wbsel)
            WB_MEM:  w_wb_val = dmem.dmem_rdata;
            WB_PC4:  w_wb_val = pc_4_in;
            default: w_wb_val = alu_in;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_err;

    // Expiry on the TIMEOUT-th WAIT cycle; a simultaneous ack takes priority.
    assign w_expire = (r_state == WAIT) && !dmem.dmem_ack &&
                      (r_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_expire;
            if (r_state == IDLE)
                r_cnt <= '0;
            else if (!dmem.dmem_ack)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    assign mem_err = r_err;
`else
    localparam int unused_timeout = TIMEOUT;
    assign w_expire = 1'b0;
    assign mem_err  = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_stall    = 1'b0;
        w_load     = 1'b0;
        w_bubble   = 1'b0;
        w_regwrite = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_next   = WAIT;
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end else begin
                    w_load     = 1'b1;
                    w_regwrite = control_in[CTL_REGW] & !control_in[CTL_BUBBLE];
                end
            end
            WAIT: begin
                if (dmem.dmem_ack) begin
                    w_next     = IDLE;
                    w_load     = 1'b1;
                    w_regwrite = control_in[CTL_REGW];
                end else if (w_expire) begin
                    w_next   = IDLE;
                    w_bubble = 1'b1;
                end else begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_req   <= (w_next == WAIT);
            if (r_state == IDLE && w_access)
                r_we <= control_in[CTL_MWRITE];
        end
    end

    // Gating with reset keeps stall low while upstream still shows a memory op.
    assign stall           = w_stall & !reset;
    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = alu_in;
    assign dmem.dmem_wdata = sw_in;

    mem_wb_reg #(.DATA_W(DATA_W)) u_mem_wb_reg (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_load),
        .i_bubble   (w_bubble),
        .i_data     (w_wb_val),
        .i_regdst   (regdst_in),
        .i_regwrite (w_regwrite),
        .o_data     (wb_data),
        .o_regdst   (wb_regdst),
        .o_regwrite (wb_regwrite)
    );
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage; timeout scenarios run when
// MEM_TIMEOUT_EN is defined (bench uses TIMEOUT = 4).
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  ctl;
    logic [31:0] pc4, alu, sw;
    logic [4:0]  rd;
    logic        stall, wb_regwrite, mem_err;
    logic [31:0] wb_data;
    logic [4:0]  wb_regdst;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  r;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    mem_wb_stage_if #(.DATA_W(32)) bus ();

    mem_wb_stage #(.DATA_W(32), .TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .control_in  (ctl),
        .pc_4_in     (pc4),
        .alu_in      (alu),
        .sw_in       (sw),
        .regdst_in   (rd),
        .dmem        (bus.master),
        .stall       (stall),
        .wb_data     (wb_data),
        .wb_regdst   (wb_regdst),
        .wb_regwrite (wb_regwrite),
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every retired register write must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && wb_regwrite === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected got data=%h rd=%0d want no write", wb_data, wb_regdst);
            end else begin
                e = q.pop_front();
                if (wb_data !== e.d || wb_regdst !== e.r) begin
                    errors++;
                    $display("FAIL wb_retire got data=%h rd=%0d want data=%h rd=%0d",
                             wb_data, wb_regdst, e.d, e.r);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; ctl = 7'h01; pc4 = '0; alu = '0; sw = '0; rd = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        tick; tick;
        checks++;
        if ({wb_data, wb_regdst, wb_regwrite, bus.dmem_req, bus.dmem_we, stall, mem_err} !== '0) begin
            errors++;
            $display("FAIL reset_state got data=%h rd=%0d wr=%b req=%b we=%b stall=%b err=%b want all 0",
                     wb_data, wb_regdst, wb_regwrite, bus.dmem_req, bus.dmem_we, stall, mem_err);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_alu_op;
        ctl = 7'h08; alu = 32'h1234; rd = 5'd5;
        q.push_back('{32'h1234, 5'd5});
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %b want 0", stall); end
        tick;
        ctl = 7'h01;
        checks++;
        if (wb_regwrite !== 1'b1 || wb_data !== 32'h1234 || wb_regdst !== 5'd5 || stall !== 1'b0) begin
            errors++;
            $display("FAIL alu_wb got wr=%b data=%h rd=%0d stall=%b want 1 1234 5 0",
                     wb_regwrite, wb_data, wb_regdst, stall);
        end
        tick;
    endtask

    task automatic test_load;
        int nst = 0, nreq = 0;
        ctl = 7'h1A; alu = 32'h40; rd = 5'd7;
        q.push_back('{32'hDEADBEEF, 5'd7});
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hDEADBEEF; end
            @(negedge clk);
            if (stall) nst++;
            if (bus.dmem_req) nreq++;
            if (c == 1) begin
                checks++;
                if (bus.dmem_addr !== 32'h40 || bus.dmem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL load_bus got addr=%h we=%b want 40 0", bus.dmem_addr, bus.dmem_we);
                end
            end
            if (c == 4) begin
                checks++;
                if (wb_regwrite !== 1'b1 || wb_data !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL load_wb got wr=%b data=%h want 1 deadbeef", wb_regwrite, wb_data);
                end
            end
            @(posedge clk); #1;
            bus.dmem_ack = 1'b0;
            if (c == 3) ctl = 7'h01;
        end
        checks++;
        if (nst != 3 || nreq != 3) begin
            errors++;
            $display("FAIL load_cycles got stall=%0d req=%0d want 3 3", nst, nreq);
        end
    endtask

    task automatic test_store;
        int nst = 0;
        ctl = 7'h04; alu = 32'h80; sw = 32'hA5A5A5A5; rd = 5'd2;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) bus.dmem_ack = 1'b1;
            @(negedge clk);
            if (stall) nst++;
            if (c == 1) begin
                checks++;
                if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1 ||
                    bus.dmem_wdata !== 32'hA5A5A5A5 || bus.dmem_addr !== 32'h80) begin
                    errors++;
                    $display("FAIL store_bus got req=%b we=%b wdata=%h addr=%h want 1 1 a5a5a5a5 80",
                             bus.dmem_req, bus.dmem_we, bus.dmem_wdata, bus.dmem_addr);
                end
            end
            if (c == 2) begin
                checks++;
                if (wb_regwrite !== 1'b0 || bus.dmem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL store_wb got wr=%b req=%b want 0 0", wb_regwrite, bus.dmem_req);
                end
            end
            @(posedge clk); #1;
            bus.dmem_ack = 1'b0;
            if (c == 1) ctl = 7'h01;
        end
        checks++;
        if (nst != 1) begin errors++; $display("FAIL store_stall got %0d want 1", nst); end
    endtask

    task automatic test_jal_bubble;
        ctl = 7'h28; pc4 = 32'h104; alu = 32'h999; rd = 5'd1;
        q.push_back('{32'h104, 5'd1});
        tick;
        ctl = 7'h01; alu = 32'h55; rd = 5'd9;
        checks++;
        if (wb_regwrite !== 1'b1 || wb_data !== 32'h104) begin
            errors++;
            $display("FAIL jal_wb got wr=%b data=%h want 1 104", wb_regwrite, wb_data);
        end
        tick;
        checks++;
        if (wb_regwrite !== 1'b0 || bus.dmem_req !== 1'b0 || stall !== 1'b0 || wb_data !== 32'h55) begin
            errors++;
            $display("FAIL bubble got wr=%b req=%b stall=%b data=%h want 0 0 0 55",
                     wb_regwrite, bus.dmem_req, stall, wb_data);
        end
        // spurious ack while idle
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hBAD0BAD0;
        tick;
        bus.dmem_ack = 1'b0;
        tick;
        checks++;
        if (bus.dmem_req !== 1'b0 || stall !== 1'b0 || wb_regwrite !== 1'b0 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack got req=%b stall=%b wr=%b err=%b want 0 0 0 0",
                     bus.dmem_req, stall, wb_regwrite, mem_err);
        end
    endtask

    task automatic test_reset_in_wait;
        ctl = 7'h1A; alu = 32'h200; rd = 5'd3;
        tick;
        checks++;
        if (bus.dmem_req !== 1'b1 || stall !== 1'b1) begin
            errors++;
            $display("FAIL rstwait_pre got req=%b stall=%b want 1 1", bus.dmem_req, stall);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.dmem_req !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL rstwait_async got req=%b stall=%b want 0 0", bus.dmem_req, stall);
        end
        tick;
        reset = 1'b0; ctl = 7'h01;
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h77777777;
        tick;
        bus.dmem_ack = 1'b0;
        tick;
        checks++;
        if (bus.dmem_req !== 1'b0 || wb_regwrite !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL rstwait_post got req=%b wr=%b stall=%b want 0 0 0",
                     bus.dmem_req, wb_regwrite, stall);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] req_v = '0, st_v = '0;
        ctl = 7'h1A; alu = 32'h10; rd = 5'd10;
        q.push_back('{32'h11111111, 5'd10});
        for (int c = 0; c < 6; c++) begin
            if (c == 1) begin bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h11111111; end
            if (c == 3) begin bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h22222222; end
            @(negedge clk);
            if (c < 4) begin req_v[c] = bus.dmem_req; st_v[c] = stall; end
            @(posedge clk); #1;
            bus.dmem_ack = 1'b0;
            if (c == 1) begin
                alu = 32'h14; rd = 5'd11;
                q.push_back('{32'h22222222, 5'd11});
            end
            if (c == 3) ctl = 7'h01;
        end
        checks++;
        if (req_v !== 4'b1010 || st_v !== 4'b0101) begin
            errors++;
            $display("FAIL b2b_pattern got req=%b stall=%b want 1010 0101", req_v, st_v);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        int nerr = 0, nst = 0;
        ctl = 7'h1A; alu = 32'h300; rd = 5'd12;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mem_err) nerr++;
            if (stall) nst++;
            if (c == 5) begin
                checks++;
                if (mem_err !== 1'b1 || bus.dmem_req !== 1'b0 || wb_regwrite !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_exp got err=%b req=%b wr=%b want 1 0 0",
                             mem_err, bus.dmem_req, wb_regwrite);
                end
            end
            @(posedge clk); #1;
            if (c == 4) ctl = 7'h01;
        end
        checks++;
        if (nerr != 1 || nst != 4) begin
            errors++;
            $display("FAIL timeout_count got err=%0d stall=%0d want 1 4", nerr, nst);
        end
    endtask

    task automatic test_ack_at_expiry;
        int nerr = 0;
        ctl = 7'h1A; alu = 32'h304; rd = 5'd13;
        q.push_back('{32'hCAFEF00D, 5'd13});
        for (int c = 0; c < 8; c++) begin
            if (c == 4) begin bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hCAFEF00D; end
            @(negedge clk);
            if (mem_err) nerr++;
            if (c == 5) begin
                checks++;
                if (wb_regwrite !== 1'b1 || wb_data !== 32'hCAFEF00D) begin
                    errors++;
                    $display("FAIL ackexp_wb got wr=%b data=%h want 1 cafef00d", wb_regwrite, wb_data);
                end
            end
            @(posedge clk); #1;
            bus.dmem_ack = 1'b0;
            if (c == 4) ctl = 7'h01;
        end
        checks++;
        if (nerr != 0) begin errors++; $display("FAIL ackexp_err got %0d pulses want 0", nerr); end
    endtask
`endif

    initial begin
        test_reset;
        test_alu_op;
        test_load;
        test_store;
        test_jal_bubble;
        test_reset_in_wait;
        test_back_to_back;
`ifdef MEM_TIMEOUT_EN
        test_timeout;
        test_ack_at_expiry;
`endif
        tick; tick;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register. Sits directly downstream of the EX/MEM register and consumes its control, PC+4, ALU result, store data and destination register.
- Drives a request/acknowledge data-memory bus. Stalls the upstream pipeline while an access is outstanding.
- Registers the selected write-back value, destination and write enable for the register file.

Parameters:
- DATA_W, 32, width of PC+4, ALU result, store data, memory data and write-back data
- TIMEOUT, 255, maximum WAIT cycles before abort; used only when MEM_TIMEOUT_EN is defined; range 1..255

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- control_in  in  7  stage control, fields:
  - [0] bubble (1 = no instruction)
  - [1] mem_read
  - [2] mem_write
  - [3] reg_write
  - [5:4] wb_sel: 00 ALU, 01 memory, 10 PC+4, 11 treated as ALU
  - [6] reserved, ignored
- pc_4_in  in  DATA_W  PC+4 of the instruction
- alu_in  in  DATA_W  ALU result; also the memory word address
- sw_in  in  DATA_W  store data
- regdst_in  in  5  destination register
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  DATA_W  address (alu_in)
- dmem_wdata  out  DATA_W  write data (sw_in)
- dmem_rdata  in  DATA_W  read data, valid with dmem_ack
- dmem_ack  in  1  one-cycle completion strobe
- stall  out  1  upstream must hold EX/MEM contents while 1
- wb_data  out  DATA_W  registered write-back value
- wb_regdst  out  5  registered destination register
- wb_regwrite  out  1  registered register-file write enable
- mem_err  out  1  one-cycle pulse on access timeout

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-high (reset).
- Reset values:
  - state = IDLE
  - dmem_req = 0, dmem_we = 0
  - wb_data = 0, wb_regdst = 0, wb_regwrite = 0
  - mem_err = 0
  - timeout counter = 0
- access = !control_in[0] & (control_in[1] | control_in[2]). If both read and write are set, treat as a write and write back as wb_sel dictates.
- FSM states: IDLE, WAIT.
- IDLE, access = 0:
  - stall = 0.
  - At the edge, MEM/WB loads wb_data per wb_sel, wb_regdst = regdst_in, wb_regwrite = control_in[3] & !control_in[0]. Latency 1 cycle.
- IDLE, access = 1:
  - stall = 1 (combinational).
  - At the edge: go to WAIT, set dmem_req = 1, latch dmem_we = control_in[2], load a bubble into MEM/WB (wb_regwrite = 0).
- WAIT:
  - dmem_req held at 1. dmem_addr and dmem_wdata follow alu_in and sw_in, which upstream holds stable.
  - stall = !dmem_ack.
  - On dmem_ack: MEM/WB loads wb_data = dmem_rdata if wb_sel = 01, else per wb_sel. wb_regwrite = control_in[3]. dmem_req drops at the same edge. Go to IDLE.
  - Minimum access costs 2 cycles in this stage (1 stall cycle).
- Every cycle with stall = 1 loads a bubble into MEM/WB. wb_data and wb_regdst hold their previous values; only wb_regwrite is cleared.
- dmem_ack while in IDLE is ignored.
- Back-to-back accesses: after an ack edge, the stage is in IDLE. The next access raises stall and dmem_req again; there is one idle cycle between requests.
- Reset asserted mid-WAIT: dmem_req drops immediately (asynchronously), state returns to IDLE, the pending access is discarded.
- wb_sel = 11: value is alu_in.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When count reaches TIMEOUT with no ack: drop dmem_req, return to IDLE, load a bubble into MEM/WB, pulse mem_err for 1 cycle, deassert stall that cycle. The instruction is retired without write-back.
  - An ack on the same cycle as expiry wins; no error is raised.
- Without the macro: no counter, WAIT lasts until ack, mem_err tied to 0.

Decomposition:
- Shared package holds:
  - control bit index constants: CTL_BUBBLE = 0, CTL_MREAD = 1, CTL_MWRITE = 2, CTL_REGW = 3, CTL_WBSEL_LO = 4, CTL_WBSEL_HI = 5
  - wb_sel encodings: WB_ALU, WB_MEM, WB_PC4
  - FSM state encodings: IDLE, WAIT
- One natural sub-module: mem_wb_reg, the MEM/WB register with load and bubble inputs and the reset values above. The FSM and write-back mux stay in mem_wb_stage.

Test Plan:
- Reset, then non-memory op (control_in = 0x08, wb_sel 00, alu_in = 0x1234, regdst = 5) -> next edge: wb_data = 0x1234, wb_regdst = 5, wb_regwrite = 1, stall = 0 throughout.
- Load (control_in = 0x1A) to addr 0x40, ack 3 cycles after req with rdata = 0xDEADBEEF -> dmem_req high exactly 3 cycles, stall high 3 cycles, then wb_data = 0xDEADBEEF, wb_regwrite = 1.
- Store (control_in = 0x04), sw_in = 0xA5A5A5A5, immediate ack -> dmem_we = 1, dmem_wdata = 0xA5A5A5A5, 1 stall cycle, wb_regwrite = 0.
- JAL-style op (control_in = 0x28, pc_4_in = 0x104) -> wb_data = 0x104. Bubble input (control_in = 0x01) -> wb_regwrite = 0, no request. Spurious ack in IDLE -> no change.
- Reset asserted during WAIT -> dmem_req = 0, stall = 0 immediately. Subsequent ack is ignored.
- MEM_TIMEOUT_EN, TIMEOUT = 4, no ack -> mem_err pulses once after 4 WAIT cycles, stall drops, wb_regwrite = 0. Ack exactly at expiry -> no mem_err, data written back.
